// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CTRL_W     = 2;
  localparam int DATA_W_DEF = 32;
  // Wide enough for the largest legal ALU latency (15).
  localparam int CNT_W      = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid requester wins, a tie goes to the
// requester that was not granted last. Grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one transaction in flight.
// Define ALU_ARB_PERF_EN to add the per-requester grant_cnt counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [2*CTRL_W-1:0]   req_ctrl,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_r,
  output logic                  rsp_zero,
  output logic                  rsp_ovf,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [CTRL_W-1:0]     alu_ctrl,
  input  logic [DATA_W-1:0]     alu_r,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  output logic                  busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]           grant_cnt
`endif
);

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             hs;
  logic             sel;

  rr_arb2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Gated by reset so nothing can be accepted on a reset edge.
  assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel       = req_ready[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_valid  <= 2'b00;
      rsp_r      <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            alu_a      <= sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            alu_b      <= sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            alu_ctrl   <= sel ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
            owner      <= sel;
            last_grant <= sel;
            cnt        <= CNT_W'(ALU_LAT);
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Counter sits at zero for one cycle so the ALU has had ALU_LAT
          // full cycles of stable operands before its outputs are sampled.
          if (cnt == '0) begin
            rsp_r     <= alu_r;
            rsp_zero  <= alu_zero;
            rsp_ovf   <= alu_ovf;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [1:0][15:0] perf_cnt;

  for (genvar i = 0; i < 2; i++) begin : g_perf
    always_ff @(posedge clk) begin
      if (reset)
        perf_cnt[i] <= '0;
      else if (req_valid[i] && req_ready[i] && perf_cnt[i] != 16'hFFFF)
        perf_cnt[i] <= perf_cnt[i] + 16'd1;
    end
  end

  assign grant_cnt = perf_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU of
// latency LAT and a transaction-level arbitration model.
module tb_alu_arbiter;

  localparam int DW  = 32;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid, req_ready, rsp_valid;
  logic [1:0]      rsp_ready = 2'b00;
  logic [2*DW-1:0] req_a, req_b;
  logic [3:0]      req_ctrl;
  logic [DW-1:0]   rsp_r, alu_a, alu_b, alu_r;
  logic            rsp_zero, rsp_ovf, alu_zero, alu_ovf, busy;
  logic [1:0]      alu_ctrl;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]     grant_cnt;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .busy(busy)
`ifdef ALU_ARB_PERF_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // Reference ALU: 00 add, 01 sub, 10 and, 11 xor; returns {ovf, zero, r}.
  function automatic logic [DW+1:0] alu_f(input logic [DW-1:0] a, b, input logic [1:0] c);
    logic [DW-1:0] r;
    logic o;
    o = 1'b0;
    case (c)
      2'd0: begin r = a + b; o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      2'd1: begin r = a - b; o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {o, (r == '0), r};
  endfunction

  // External ALU with exactly LAT cycles from operand change to result.
  logic [DW+1:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= alu_f(alu_a, alu_b, alu_ctrl);
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign {alu_ovf, alu_zero, alu_r} = apipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic id; logic [DW+1:0] res; int t; } exp_t;
  exp_t sbq[$];

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model state
  logic          last_g = 1'b1;
  logic          in_flight = 1'b0;
  logic          release_req = 1'b0;
  int            pcnt [2];
  logic          pend [2];
  logic [DW-1:0] pa [2], pb [2];
  logic [1:0]    pc [2];
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic [1:0]    op_c = '0;
  int            gen_pct = 0, drop_pct = 0;
  int            rr_mode = 1;
  logic          log_en = 1'b0;
  logic          dseq[$];
  logic          prev_vld = 1'b0;
  logic [DW+1:0] prev_res;

  task automatic drive_cycle();
    logic [1:0] v, eg;
    logic id;
    @(negedge clk);
    if (release_req) begin in_flight = 1'b0; release_req = 1'b0; end
    chk("alu_a", alu_a, op_a);
    chk("alu_b", alu_b, op_b);
    chk("alu_ctrl", alu_ctrl, op_c);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(99) < gen_pct) begin
        pend[i] = 1'b1;
        pa[i] = $urandom;
        pb[i] = ($urandom_range(7) == 0) ? pa[i] : $urandom;
        pc[i] = 2'($urandom_range(3));
      end
      v[i] = pend[i] && ($urandom_range(99) >= drop_pct);
    end
    req_valid = v;
    req_a = {pa[1], pa[0]};
    req_b = {pb[1], pb[0]};
    req_ctrl = {pc[1], pc[0]};
    #2;
    chk("busy", busy, in_flight);
    eg = 2'b00;
    if (!in_flight) begin
      if (v == 2'b01) eg = 2'b01;
      else if (v == 2'b10) eg = 2'b10;
      else if (v == 2'b11) eg = last_g ? 2'b01 : 2'b10;
    end
    chk("req_ready", req_ready, eg);
    if (log_en && req_ready != 2'b00) dseq.push_back(req_ready[1]);
    if (eg != 2'b00) begin
      id = eg[1];
      sbq.push_back('{id, alu_f(pa[id], pb[id], pc[id]), cyc + 1});
      in_flight = 1'b1;
      last_g = id;
      pend[id] = 1'b0;
      op_a = pa[id]; op_b = pb[id]; op_c = pc[id];
      if (pcnt[id] < 65535) pcnt[id]++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b11;
    in_flight = 1'b0; release_req = 1'b0; sbq.delete(); last_g = 1'b1;
    prev_vld = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
    op_a = '0; op_b = '0; op_c = '0; pcnt[0] = 0; pcnt[1] = 0;
    #2;
    chk("req_ready in reset", req_ready, 2'b00);
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b00;
    #2;
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_valid", rsp_valid, 2'b00);
    chk("reset rsp", {rsp_ovf, rsp_zero, rsp_r}, '0);
  endtask

  // Monitor: owns rsp_ready and pops the scoreboard on each response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      rsp_ready = (rr_mode == 1) ? 2'b11 : (rr_mode == 2) ? 2'b00 : 2'($urandom_range(3));
      #1;
      if (!reset) begin
        if (sbq.size() == 0) begin
          chk("spurious rsp_valid", rsp_valid, 2'b00);
        end else begin
          e = sbq[0];
          if (rsp_valid != 2'b00) begin
            chk("rsp_valid owner", rsp_valid, e.id ? 2'b10 : 2'b01);
            if (!prev_vld) chk("rsp latency", cyc - e.t, LAT + 1);
            else           chk("rsp hold", {rsp_ovf, rsp_zero, rsp_r}, prev_res);
            chk("rsp data", {rsp_ovf, rsp_zero, rsp_r}, e.res);
            prev_res = {rsp_ovf, rsp_zero, rsp_r};
            if (rsp_ready[e.id]) begin
              void'(sbq.pop_front());
              release_req = 1'b1;
              prev_vld = 1'b0;
            end else begin
              prev_vld = 1'b1;
            end
          end else if (cyc - e.t > LAT + 1) begin
            chk("rsp missing", rsp_valid, e.id ? 2'b10 : 2'b01);
            void'(sbq.pop_front());
            release_req = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b00; req_a = '0; req_b = '0; req_ctrl = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin pa[i] = '0; pb[i] = '0; pc[i] = '0; end
    do_reset(3);

    // Tie straight out of reset goes to requester 0; 5 + 3 = 8.
    pend[0] = 1'b1; pa[0] = 5;  pb[0] = 3; pc[0] = 2'b00;
    pend[1] = 1'b1; pa[1] = 77; pb[1] = 77; pc[1] = 2'b11;
    repeat (14) drive_cycle();

    // Both held valid: grants alternate.
    do_reset(2);
    dseq.delete(); log_en = 1'b1; gen_pct = 100;
    for (int k = 0; k < 200 && dseq.size() < 6; k++) drive_cycle();
    log_en = 1'b0; gen_pct = 0;
    chk("alternation count", dseq.size(), 6);
    for (int k = 0; k < 6 && k < dseq.size(); k++) chk("alternation grant", dseq[k], k % 2);

    // Lone requester 1 with a held response (rsp_ready low).
    do_reset(2);
    rr_mode = 2;
    pend[1] = 1'b1; pa[1] = 32'h7FFF_FFFF; pb[1] = 1; pc[1] = 2'b00;
    repeat (12) drive_cycle();
    rr_mode = 1;
    repeat (4) drive_cycle();

    // Reset while the op is in EXEC: it must never respond.
    do_reset(2);
    pend[0] = 1'b1; pa[0] = 9; pb[0] = 9; pc[0] = 2'b01;
    for (int k = 0; k < 5 && !in_flight; k++) drive_cycle();
    drive_cycle();
    do_reset(1);
    repeat (10) drive_cycle();

    // Randomized traffic with valid drops and random rsp backpressure.
    gen_pct = 40; drop_pct = 25; rr_mode = 0;
    repeat (2000) drive_cycle();

    gen_pct = 0; drop_pct = 0; rr_mode = 1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int k = 0; k < 100 && (in_flight || sbq.size() != 0); k++) drive_cycle();
    drive_cycle();
    chk("drained busy", busy, 1'b0);
`ifdef ALU_ARB_PERF_EN
    chk("grant_cnt", grant_cnt, {16'(pcnt[1]), 16'(pcnt[0])});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, ALU operand/result width.
REQ-002 Parameter ALU_LAT, default 1, cycles from ALU operand drive to valid alu_r/alu_zero/alu_ovf; legal range 1..15.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  2  request valid, bit i = requester i.
REQ-006 req_ready  out  2  request accepted this cycle, bit i = requester i.
REQ-007 req_a  in  2*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W].
REQ-008 req_b  in  2*DATA_W  operand B, same packing.
REQ-009 req_ctrl  in  4  ALU op code, requester i at [2i+1:2i].
REQ-010 rsp_valid  out  2  result valid for requester i.
REQ-011 rsp_ready  in  2  requester i consumes result.
REQ-012 rsp_r  out  DATA_W  result; rsp_zero out 1 zero flag; rsp_ovf out 1 overflow flag.
REQ-013 alu_a, alu_b  out  DATA_W each; alu_ctrl out 2: ALU operand/op drive.
REQ-014 alu_r  in  DATA_W; alu_zero in 1; alu_ovf in 1: ALU outputs.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on handshake, EXEC->RESP after ALU_LAT cycles, RESP->IDLE on rsp handshake of owner.
REQ-017 In IDLE, grant is round-robin among valid requesters: single valid wins; both valid -> requester != last_grant wins.
REQ-018 req_ready[i] SHALL be 1 only in IDLE and only for the granted requester, at most one bit set; req_ready never depends on req_ready/rsp_ready of the other port.
REQ-019 On handshake (req_valid[i] & req_ready[i]) operands and ctrl of requester i are registered into alu_a/alu_b/alu_ctrl, owner <= i, last_grant <= i, cycle counter loaded with ALU_LAT.
REQ-020 alu_a/alu_b/alu_ctrl SHALL hold stable from handshake until the next handshake.
REQ-021 In EXEC the counter decrements each cycle; on the cycle it reaches 0, alu_r/alu_zero/alu_ovf are captured into rsp_r/rsp_zero/rsp_ovf and state -> RESP.
REQ-022 Latency: handshake at edge t -> rsp_valid[owner] high from edge t+ALU_LAT+1.
REQ-023 In RESP rsp_valid[owner]=1, other bit 0; rsp_r/zero/ovf stable until rsp_ready[owner]; rsp_ready of non-owner ignored.
REQ-024 rsp handshake -> IDLE next cycle; new request cannot be accepted in the same cycle (one transaction in flight).
REQ-025 req_valid deasserted while not granted is legal; no request is lost once accepted.

Reset
REQ-026 reset SHALL force state IDLE, last_grant=1 (requester 0 wins first tie), counter 0, owner 0.
REQ-027 Reset values: req_ready=0 during reset cycle, rsp_valid=0, rsp_r=0, rsp_zero=0, rsp_ovf=0, alu_a=0, alu_b=0, alu_ctrl=2'b00, busy=0.
REQ-028 Reset mid-EXEC or mid-RESP SHALL abandon the transaction; no response is ever produced for it.

Configuration
REQ-029 Macro ALU_ARB_PERF_EN defined: output grant_cnt (32 bits, requester i at [16i+15:16i]) counts accepted requests per requester, 16-bit saturating at 16'hFFFF, cleared by reset.
REQ-030 Macro ALU_ARB_PERF_EN undefined: grant_cnt port and counters absent; all other behaviour identical.

Structure
REQ-031 Package alu_arb_pkg SHALL hold the FSM state enum, ALU ctrl width (2), default DATA_W, counter width constant.
REQ-032 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant (inputs valid[1:0], last_grant; output grant[1:0], one-hot or zero).

Verification
REQ-033 After reset, req_valid=2'b11, req0 a=5,b=3,ctrl=2'b00 -> req_ready=2'b01 first; alu_a=5, alu_b=3 next cycle; rsp_valid=2'b01 at t+ALU_LAT+1 with rsp_r = ALU result.
REQ-034 Both requesters held valid for 6 transactions, rsp_ready=2'b11 -> grants alternate 0,1,0,1,0,1.
REQ-035 Result held with rsp_ready[owner]=0 for 5 cycles -> rsp_valid and rsp_r unchanged, no new req_ready.
REQ-036 ALU_LAT=3, single request from requester 1 -> rsp_valid=2'b10 exactly 4 cycles after handshake.
REQ-037 reset asserted in EXEC -> next cycle state IDLE, rsp_valid=0, busy=0; no later response for aborted op.
REQ-038 With ALU_ARB_PERF_EN, 70000 grants to requester 0 -> grant_cnt[15:0]=16'hFFFF, grant_cnt[31:16]=0.
